// File: rtl/step_counter.sv
// Parametrised up/down step counter with modulus, load, clear, saturate mode
// and terminal-count / wrap / load-error flags for the control path.
module step_counter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MODULUS  = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Enable,
    input  logic             Up,
    output logic [WIDTH-1:0] Count,
    output logic             TermCount,
    output logic             Wrap,
    output logic             LoadErr
);

    localparam int unsigned MAX_INT = MODULUS - 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_INT);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam bit               SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             load_err_next;
    logic             at_max;
    logic             at_zero;
    logic             load_oor;

    assign at_max   = (Count == MAX_VAL);
    assign at_zero  = (Count == ZERO);
    assign load_oor = (32'(LoadValue) > MAX_INT);

    // Valid in the cycle before the edge that wraps or holds at a range end.
    assign TermCount = Enable & ((Up & at_max) | (~Up & at_zero));

    // Next-state: Clear > Load > Enable > hold; flags pulse for one cycle only.
    always_comb begin
        count_next    = Count;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (Clear) begin
            count_next = ZERO;
        end else if (Load) begin
            if (load_oor) begin
                count_next    = MAX_VAL;
                load_err_next = 1'b1;
            end else begin
                count_next = LoadValue;
            end
        end else if (Enable) begin
            if (Up) begin
                if (!at_max) begin
                    count_next = Count + ONE;
                end else if (!SAT) begin
                    count_next = ZERO;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_next = Count - ONE;
                end else if (!SAT) begin
                    count_next = MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Count   <= ZERO;
            Wrap    <= 1'b0;
            LoadErr <= 1'b0;
        end else begin
            Count   <= count_next;
            Wrap    <= wrap_next;
            LoadErr <= load_err_next;
        end
    end

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: three instances (3b/mod8 wrap,
// 4b/mod10 wrap, 3b/mod8 saturate) share stimulus; each task checks one.
module tb_step_counter;

    logic       Clock;
    logic       Resetn;
    logic       Clear;
    logic       Load;
    logic [3:0] LoadValue;
    logic       Enable;
    logic       Up;

    logic [2:0] count_a;
    logic       tc_a, wrap_a, err_a;
    logic [3:0] count_b;
    logic       tc_b, wrap_b, err_b;
    logic [2:0] count_c;
    logic       tc_c, wrap_c, err_c;

    int total = 0;
    int bad   = 0;

    step_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .Load(Load),
        .LoadValue(LoadValue[2:0]), .Enable(Enable), .Up(Up),
        .Count(count_a), .TermCount(tc_a), .Wrap(wrap_a), .LoadErr(err_a)
    );

    step_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .Load(Load),
        .LoadValue(LoadValue), .Enable(Enable), .Up(Up),
        .Count(count_b), .TermCount(tc_b), .Wrap(wrap_b), .LoadErr(err_b)
    );

    step_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) dut_c (
        .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .Load(Load),
        .LoadValue(LoadValue[2:0]), .Enable(Enable), .Up(Up),
        .Count(count_c), .TermCount(tc_c), .Wrap(wrap_c), .LoadErr(err_c)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_in(input logic clr, input logic ld, input logic [3:0] lv,
                          input logic en, input logic up);
        Clear = clr; Load = ld; LoadValue = lv; Enable = en; Up = up;
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 4'd0, 0, 1);
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (count_a !== 3'd0 || wrap_a !== 1'b0 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a count=%0d wrap=%b err=%b expected 0/0/0", count_a, wrap_a, err_a);
        end
        total++;
        if (count_b !== 4'd0 || wrap_b !== 1'b0 || err_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b count=%0d wrap=%b err=%b expected 0/0/0", count_b, wrap_b, err_b);
        end
        total++;
        if (count_c !== 3'd0 || wrap_c !== 1'b0 || err_c !== 1'b0) begin
            bad++;
            $display("FAIL reset_c count=%0d wrap=%b err=%b expected 0/0/0", count_c, wrap_c, err_c);
        end
        set_in(0, 0, 4'd0, 1, 1);
        total++;
        if (tc_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_tc_up got=%b expected 0", tc_a);
        end
        set_in(0, 0, 4'd0, 1, 0);
        total++;
        if (tc_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_tc_down got=%b expected 1", tc_a);
        end
        set_in(0, 0, 4'd0, 0, 0);
    endtask

    task automatic test_up_wrap();
        logic [2:0] exp;
        do_reset();
        set_in(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = 3'((i + 1) % 8);
            total++;
            if (count_a !== exp) begin
                bad++;
                $display("FAIL up_count step=%0d got=%0d expected %0d", i, count_a, exp);
            end
            total++;
            if (wrap_a !== (exp == 3'd0)) begin
                bad++;
                $display("FAIL up_wrap step=%0d got=%b expected %b", i, wrap_a, exp == 3'd0);
            end
            total++;
            if (tc_a !== (exp == 3'd7)) begin
                bad++;
                $display("FAIL up_tc step=%0d got=%b expected %b", i, tc_a, exp == 3'd7);
            end
        end
    endtask

    task automatic test_down_mod10();
        logic [3:0] exp;
        do_reset();
        set_in(0, 0, 4'd0, 1, 0);
        total++;
        if (tc_b !== 1'b1) begin
            bad++;
            $display("FAIL down_tc_start got=%b expected 1", tc_b);
        end
        for (int i = 0; i < 11; i++) begin
            tick();
            exp = 4'((10 - ((i + 1) % 10)) % 10);
            total++;
            if (count_b !== exp) begin
                bad++;
                $display("FAIL down_count step=%0d got=%0d expected %0d", i, count_b, exp);
            end
            total++;
            if (wrap_b !== (exp == 4'd9)) begin
                bad++;
                $display("FAIL down_wrap step=%0d got=%b expected %b", i, wrap_b, exp == 4'd9);
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        set_in(0, 1, 4'd12, 0, 1);
        tick();
        total++;
        if (count_b !== 4'd9 || err_b !== 1'b1 || wrap_b !== 1'b0) begin
            bad++;
            $display("FAIL load_oor count=%0d err=%b wrap=%b expected 9/1/0", count_b, err_b, wrap_b);
        end
        set_in(0, 0, 4'd0, 0, 1);
        tick();
        total++;
        if (count_b !== 4'd9 || err_b !== 1'b0) begin
            bad++;
            $display("FAIL load_err_pulse count=%0d err=%b expected 9/0", count_b, err_b);
        end
        set_in(0, 1, 4'd4, 0, 1);
        tick();
        total++;
        if (count_b !== 4'd4 || err_b !== 1'b0) begin
            bad++;
            $display("FAIL load_ok count=%0d err=%b expected 4/0", count_b, err_b);
        end
        set_in(0, 1, 4'd9, 1, 1);
        tick();
        total++;
        if (count_b !== 4'd9 || wrap_b !== 1'b0) begin
            bad++;
            $display("FAIL load_vs_enable count=%0d wrap=%b expected 9/0", count_b, wrap_b);
        end
        set_in(0, 0, 4'd0, 1, 1);
        total++;
        if (tc_b !== 1'b1) begin
            bad++;
            $display("FAIL load_tc got=%b expected 1", tc_b);
        end
        tick();
        total++;
        if (count_b !== 4'd0 || wrap_b !== 1'b1) begin
            bad++;
            $display("FAIL load_then_wrap count=%0d wrap=%b expected 0/1", count_b, wrap_b);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] exp;
        do_reset();
        set_in(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
            total++;
            if (count_c !== exp || wrap_c !== 1'b0) begin
                bad++;
                $display("FAIL sat_up step=%0d count=%0d wrap=%b expected %0d/0", i, count_c, wrap_c, exp);
            end
        end
        total++;
        if (tc_c !== 1'b1) begin
            bad++;
            $display("FAIL sat_tc_top got=%b expected 1", tc_c);
        end
        set_in(0, 0, 4'd0, 1, 0);
        total++;
        if (tc_c !== 1'b0) begin
            bad++;
            $display("FAIL sat_tc_dirflip got=%b expected 0", tc_c);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            exp = (i > 6) ? 3'd0 : 3'(6 - i);
            total++;
            if (count_c !== exp || wrap_c !== 1'b0) begin
                bad++;
                $display("FAIL sat_down step=%0d count=%0d wrap=%b expected %0d/0", i, count_c, wrap_c, exp);
            end
        end
    endtask

    task automatic test_clear_priority();
        do_reset();
        set_in(0, 1, 4'd5, 0, 1);
        tick();
        total++;
        if (count_a !== 3'd5 || count_b !== 4'd5) begin
            bad++;
            $display("FAIL clr_preload a=%0d b=%0d expected 5/5", count_a, count_b);
        end
        set_in(1, 1, 4'd12, 1, 1);
        tick();
        total++;
        if (count_a !== 3'd0 || count_b !== 4'd0 || err_b !== 1'b0 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL clr_over_load a=%0d b=%0d err_a=%b err_b=%b expected 0/0/0/0",
                     count_a, count_b, err_a, err_b);
        end
        set_in(0, 0, 4'd0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count_a !== 3'd0 || count_b !== 4'd0) begin
                bad++;
                $display("FAIL hold step=%0d a=%0d b=%0d expected 0/0", i, count_a, count_b);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(0, 1, 4'd14, 0, 1);
        tick();
        total++;
        if (count_a !== 3'd6 || count_b !== 4'd9 || err_b !== 1'b1) begin
            bad++;
            $display("FAIL ares_setup a=%0d b=%0d err_b=%b expected 6/9/1", count_a, count_b, err_b);
        end
        set_in(0, 0, 4'd0, 1, 1);
        Resetn = 1'b0;
        #1;
        total++;
        if (count_a !== 3'd0 || count_b !== 4'd0 || err_b !== 1'b0 || wrap_a !== 1'b0) begin
            bad++;
            $display("FAIL ares_immediate a=%0d b=%0d err_b=%b wrap_a=%b expected 0/0/0/0",
                     count_a, count_b, err_b, wrap_a);
        end
        total++;
        if (tc_a !== 1'b0) begin
            bad++;
            $display("FAIL ares_tc_up got=%b expected 0", tc_a);
        end
        Up = 1'b0;
        #1;
        total++;
        if (tc_a !== 1'b1) begin
            bad++;
            $display("FAIL ares_tc_down got=%b expected 1", tc_a);
        end
        Up = 1'b1;
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        total++;
        if (count_a !== 3'd1 || count_b !== 4'd1 || wrap_a !== 1'b0) begin
            bad++;
            $display("FAIL ares_restart a=%0d b=%0d wrap_a=%b expected 1/1/0", count_a, count_b, wrap_a);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        set_in(0, 0, 4'd0, 0, 1);
        test_reset();
        test_up_wrap();
        test_down_mod10();
        test_load();
        test_saturate();
        test_clear_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised step counter for the processor control path. It generalises the fixed 3-bit free-running step counter with configurable width and modulus, up/down direction, count enable, parallel load, a saturate mode and terminal-count/wrap flags. It sits beside the control FSM, which uses it to sequence instruction time steps (T0..Tn) and as a general-purpose loop/timeout counter.

## Interface
- WIDTH, 3, bit width of Count; 1..16.
- MODULUS, 8, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.
- Clock  in  1  rising-edge clock; the only clock.
- Resetn  in  1  asynchronous, active-low reset.
- Clear  in  1  synchronous clear to 0, active high.
- Load  in  1  synchronous parallel load of LoadValue.
- LoadValue  in  WIDTH  value for Load.
- Enable  in  1  count enable.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Count  out  WIDTH  registered count.
- TermCount  out  1  combinational: Enable & ((Up & Count==MODULUS-1) | (~Up & Count==0)).
- Wrap  out  1  registered one-cycle pulse after a wrap transition.
- LoadErr  out  1  registered one-cycle pulse after an out-of-range load.

## Operation
- Resetn low, asynchronously: Count=0, Wrap=0, LoadErr=0. Takes effect immediately and holds while low. First update is on the first rising Clock edge after Resetn goes high.
- Per rising edge, priority is Clear > Load > Enable > hold.
- Clear: Count<=0. Wrap and LoadErr <=0.
- Load with LoadValue <= MODULUS-1: Count<=LoadValue, LoadErr<=0.
- Load with LoadValue >= MODULUS: Count<=MODULUS-1, LoadErr<=1.
- Load overrides Enable. Load never sets Wrap.
- Enable & Up:
  - Count<MODULUS-1: Count+1.
  - Count==MODULUS-1, SATURATE=0: Count<=0, Wrap<=1.
  - Count==MODULUS-1, SATURATE=1: hold, Wrap<=0.
- Enable & ~Up:
  - Count>0: Count-1.
  - Count==0, SATURATE=0: Count<=MODULUS-1, Wrap<=1.
  - Count==0, SATURATE=1: hold.
- Enable low: Count holds.
- Wrap and LoadErr default to 0 on every edge where their set condition is absent, so each is a single-cycle pulse.
- Arithmetic is modulo MODULUS, never modulo 2**WIDTH. When MODULUS==2**WIDTH, behaviour equals natural WIDTH-bit wrap.
- Up may change every cycle. Direction is sampled at the same edge as Enable.
- Changing Up while Count sits at a limit changes TermCount in the same cycle. This is legal.

## Timing
- Count, Wrap and LoadErr change only on a rising Clock edge, except the asynchronous reset.
- Latency is 1 cycle from Clear, Load or Enable sampled high to the new Count.
- Wrap and LoadErr are visible in the same cycle as the Count value that produced them, and last exactly 1 cycle.
- TermCount is combinational from Count, Enable and Up. It is valid in the cycle before the wrap/hold edge, so the FSM can act on it without extra latency.
- Reset release mid-sequence: counting restarts from 0. No pending Wrap or LoadErr survives reset.
- Reset asserted mid-count: all outputs reach reset values without a Clock edge. TermCount follows Count=0, so it reads Enable & ~Up.

## Test plan
- Defaults, reset then Enable=1, Up=1 for 10 cycles -> Count 1,2,..,7,0,1,2. Wrap high only in the cycle Count=0. TermCount high only while Count=7.
- WIDTH=4, MODULUS=10, Up=0, starting from reset -> first edge gives Count=9 with Wrap=1, then 8,7,..,0, then 9 again with Wrap=1. Count never shows 15..10.
- WIDTH=4, MODULUS=10, Load with LoadValue=12 -> Count=9, LoadErr=1 for one cycle. LoadValue=4 -> Count=4, LoadErr=0. Load and Enable together -> load wins.
- SATURATE=1, defaults, Enable=1, Up=1 for 12 cycles -> Count reaches 7 and holds, Wrap never asserts. Switch Up=0 -> 6,5,..,0 and holds at 0.
- Clear and Load asserted together at Count=5 -> Count=0, LoadErr=0. Enable=0 for 3 cycles -> Count holds at 0.
- Resetn pulsed low between edges at Count=6 -> Count=0 immediately, before the next edge. After release with Enable=1, Up=1 -> Count=1 on the first edge.
